// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the I-cache refill engine.
package icache_refill_pkg;

    localparam int unsigned INST_ADDR_W = 64;
    localparam int unsigned INST_W      = 64;
    localparam int unsigned LEN_W       = 8;
    localparam int unsigned RESP_W      = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_t;

    function automatic logic resp_ok(input logic [RESP_W-1:0] resp);
        return resp == RESP_OKAY;
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Instruction memory read bus (address + data channels) seen by the refill engine.
interface icache_refill_if
    import icache_refill_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W,
    parameter int unsigned DATA_W = INST_W
);
    logic              ArValid;
    logic              ArReady;
    logic [ADDR_W-1:0] ArAddr;
    logic [LEN_W-1:0]  ArLen;
    logic              RValid;
    logic              RReady;
    logic [DATA_W-1:0] RData;
    logic [RESP_W-1:0] RResp;
    logic              RLast;

    modport master (
        output ArValid, ArAddr, ArLen, RReady,
        input  ArReady, RValid, RData, RResp, RLast
    );

    modport slave (
        input  ArValid, ArAddr, ArLen, RReady,
        output ArReady, RValid, RData, RResp, RLast
    );
endinterface

// File: rtl/icache_refill.sv
// Refill engine: one burst read per cache miss, each returned word written into the cache.
// A redirect (Flush) or an error beat stops writing and drains the rest of the burst.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned ADDR_W    = INST_ADDR_W,
    parameter int unsigned DATA_W    = INST_W,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned STRIDE    = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] PcIn,
    input  logic              CacheMissing,
    input  logic              Flush,
    output logic [ADDR_W-1:0] PrePcOut,
    output logic [DATA_W-1:0] InstOut,
    output logic              ReadShakeHands,
    output logic              RefillBusy,
    output logic              FetchError,
    icache_refill_if.master   bus
);

    localparam int unsigned CNT_W = unsigned'($clog2(BURST_LEN + 1));

    refill_state_t     r_state;
    refill_state_t     w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_beat_addr;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [LEN_W-1:0]  r_ar_len;
    logic              r_ar_valid;
    logic              r_rready;
    logic              r_flush_seen;
    logic [ADDR_W-1:0] r_pre_pc;
    logic [DATA_W-1:0] r_inst;
    logic              r_wr;
    logic              r_busy;
    logic              r_err;

    logic [ADDR_W-1:0] w_aligned;
    logic              w_accept;
    logic              w_wr;
    logic              w_err;
    logic              w_start;

    assign w_aligned = PcIn & ~ADDR_W'(3);
    assign w_accept  = bus.RValid && r_rready;

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-beat write/error decisions
    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_err   = 1'b0;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (CacheMissing && !Flush) begin
                    w_start = 1'b1;
                    w_next  = ST_AR;
                end
            end
            ST_AR: begin
                if (r_ar_valid && bus.ArReady) begin
                    w_next = (r_flush_seen || Flush) ? ST_DRAIN : ST_R;
                end
            end
            ST_R: begin
                if (Flush) begin
                    w_next = (w_accept && bus.RLast) ? ST_DONE : ST_DRAIN;
                end else if (w_accept) begin
                    if (!resp_ok(bus.RResp)) begin
                        w_err  = 1'b1;
                        w_next = bus.RLast ? ST_DONE : ST_DRAIN;
                    end else begin
                        w_wr = (r_cnt < CNT_W'(BURST_LEN));
                        if (bus.RLast) begin
                            w_next = ST_DONE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_accept && bus.RLast) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Registered bus controls, cache write port and burst bookkeeping
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt        <= '0;
            r_beat_addr  <= '0;
            r_ar_addr    <= '0;
            r_ar_len     <= '0;
            r_ar_valid   <= 1'b0;
            r_rready     <= 1'b0;
            r_flush_seen <= 1'b0;
            r_pre_pc     <= '0;
            r_inst       <= '0;
            r_wr         <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ar_valid <= (w_next == ST_AR);
            r_rready   <= (w_next == ST_R) || (w_next == ST_DRAIN);
            r_busy     <= (w_next != ST_IDLE);
            r_wr       <= w_wr;
            r_err      <= w_err;

            if (w_start) begin
                r_ar_addr    <= w_aligned;
                r_ar_len     <= LEN_W'(BURST_LEN - 1);
                r_beat_addr  <= w_aligned;
                r_cnt        <= '0;
                r_flush_seen <= 1'b0;
            end else if (r_state == ST_AR && Flush) begin
                r_flush_seen <= 1'b1;
            end

            // Running address wraps naturally at the top of the address space
            if (w_wr) begin
                r_pre_pc    <= r_beat_addr;
                r_inst      <= bus.RData;
                r_beat_addr <= r_beat_addr + ADDR_W'(STRIDE);
                r_cnt       <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ArValid    = r_ar_valid;
    assign bus.ArAddr     = r_ar_addr;
    assign bus.ArLen      = r_ar_len;
    assign bus.RReady     = r_rready;
    assign PrePcOut       = r_pre_pc;
    assign InstOut        = r_inst;
    assign ReadShakeHands = r_wr;
    assign RefillBusy     = r_busy;
    assign FetchError     = r_err;

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill against a burst-level model of the expected cache writes.
module tb_icache_refill;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned BL  = 8;
    localparam int unsigned STR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc_in;
    logic          cache_missing;
    logic          flush;
    logic [AW-1:0] pre_pc;
    logic [DW-1:0] inst;
    logic          rsh;
    logic          busy;
    logic          ferr;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    int          fe_cnt = 0;

    icache_refill_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    icache_refill #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .STRIDE(STR)) dut (
        .Clk           (clk),
        .Rst           (rst_n),
        .PcIn          (pc_in),
        .CacheMissing  (cache_missing),
        .Flush         (flush),
        .PrePcOut      (pre_pc),
        .InstOut       (inst),
        .ReadShakeHands(rsh),
        .RefillBusy    (busy),
        .FetchError    (ferr),
        .bus           (bus_if.master)
    );

    always #5 clk = ~clk;

    // Cache-side observer
    always @(negedge clk) begin
        if (rsh) begin
            wr_addr_q.push_back(pre_pc);
            wr_data_q.push_back(inst);
        end
        if (ferr) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_refill(input logic [63:0] pc, input int ar_delay, input int flush_ar,
                              input int nbeats, input int err_beat, input int flush_beat,
                              input int bubble_pct, input int rst_beat);
        logic [63:0] pc_al;
        logic [63:0] data[$];
        logic [63:0] exp_a[$];
        logic [63:0] exp_d[$];
        int          exp_fe;
        int          wr0;
        int          fe0;
        int          nwr;
        bit          seen;

        pc_al = pc & ~64'h3;
        for (int b = 0; b < nbeats; b++) data.push_back({$urandom, $urandom});

        // Expected writes: consecutive beats from the aligned miss PC until a stop event
        exp_fe = 0;
        if (flush_ar < 0) begin
            for (int b = 0; b < nbeats; b++) begin
                if (b == rst_beat || b == flush_beat) break;
                if (b == err_beat) begin
                    exp_fe = 1;
                    break;
                end
                if (b < int'(BL)) begin
                    exp_a.push_back(pc_al + 64'(STR * b));
                    exp_d.push_back(data[b]);
                end
            end
        end

        wr0 = wr_addr_q.size();
        fe0 = fe_cnt;

        pc_in = pc;
        cache_missing = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = bus_if.ArValid;
        end
        chk("ar_start", 64'(seen), 64'd1);
        cache_missing = 1'b0;
        if (!seen) return;

        for (int i = 0; i <= ar_delay; i++) begin
            chk("ar_valid", 64'(bus_if.ArValid), 64'd1);
            chk("ar_addr", bus_if.ArAddr, pc_al);
            chk("ar_len", 64'(bus_if.ArLen), 64'(BL - 1));
            bus_if.ArReady = (i == ar_delay);
            flush = (i == flush_ar);
            tick();
        end
        bus_if.ArReady = 1'b0;
        flush = 1'b0;
        chk("ar_drop", 64'(bus_if.ArValid), 64'd0);

        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < 6 && bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct; g++) begin
                bus_if.RValid = 1'b0;
                tick();
            end
            chk("r_ready", 64'(bus_if.RReady), 64'd1);
            chk("busy_burst", 64'(busy), 64'd1);
            bus_if.RValid = 1'b1;
            bus_if.RData  = data[b];
            bus_if.RResp  = (b == err_beat) ? 2'b10 : 2'b00;
            bus_if.RLast  = (b == nbeats - 1);
            flush = (b == flush_beat);
            tick();
            bus_if.RValid = 1'b0;
            bus_if.RLast  = 1'b0;
            flush = 1'b0;
            if (b == rst_beat) begin
                chk("wr_pending", 64'(rsh), 64'd1);
                rst_n = 1'b0;
                #1;
                chk("rst_rsh", 64'(rsh), 64'd0);
                chk("rst_arvalid", 64'(bus_if.ArValid), 64'd0);
                chk("rst_rready", 64'(bus_if.RReady), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                tick();
                rst_n = 1'b1;
                break;
            end
        end

        repeat (3) tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_arvalid", 64'(bus_if.ArValid), 64'd0);
        chk("idle_rready", 64'(bus_if.RReady), 64'd0);

        nwr = wr_addr_q.size() - wr0;
        chk("wr_count", 64'(nwr), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < nwr; i++) begin
            chk("wr_addr", wr_addr_q[wr0 + i], exp_a[i]);
            chk("wr_data", wr_data_q[wr0 + i], exp_d[i]);
        end
        chk("fetch_err", 64'(fe_cnt - fe0), 64'(exp_fe));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb;
        int mode;
        int dly;
        int pick;

        rst_n = 1'b0;
        pc_in = '0;
        cache_missing = 1'b0;
        flush = 1'b0;
        bus_if.ArReady = 1'b0;
        bus_if.RValid  = 1'b0;
        bus_if.RData   = '0;
        bus_if.RResp   = 2'b00;
        bus_if.RLast   = 1'b0;
        #2;
        chk("rst_rsh0", 64'(rsh), 64'd0);
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_ferr0", 64'(ferr), 64'd0);
        chk("rst_arvalid0", 64'(bus_if.ArValid), 64'd0);
        chk("rst_rready0", 64'(bus_if.RReady), 64'd0);
        chk("rst_prepc0", pre_pc, 64'd0);
        chk("rst_arlen0", 64'(bus_if.ArLen), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Flush in IDLE suppresses the start of a refill
        cache_missing = 1'b1;
        flush = 1'b1;
        tick();
        cache_missing = 1'b0;
        flush = 1'b0;
        chk("idle_flush_arvalid", 64'(bus_if.ArValid), 64'd0);
        chk("idle_flush_busy", 64'(busy), 64'd0);

        run_refill(64'h0000_0000_8000_0010, 0, -1, 8, -1, -1, 0, -1);
        run_refill(64'h0000_0000_8000_0100, 5, 2, 8, -1, -1, 0, -1);
        run_refill(64'h0000_0000_8000_0200, 1, -1, 8, 3, -1, 0, -1);
        run_refill(64'h0000_0000_8000_0300, 0, -1, 8, -1, 4, 40, -1);
        run_refill(64'hFFFF_FFFF_FFFF_FFF8, 0, -1, 8, -1, -1, 0, -1);
        run_refill(64'h0000_0000_8000_0400, 0, -1, 8, -1, -1, 0, 3);
        run_refill(64'h0000_0000_8000_0503, 2, -1, 8, -1, -1, 20, -1);
        run_refill(64'h0000_0000_8000_0600, 0, -1, 10, -1, -1, 0, -1);

        for (int k = 0; k < 10; k++) begin
            pick = int'($urandom_range(2));
            nb   = (pick == 0) ? 5 : ((pick == 1) ? 8 : 10);
            dly  = int'($urandom_range(3));
            mode = int'($urandom_range(3));
            case (mode)
                1:       run_refill({$urandom, $urandom}, dly, -1, nb, int'($urandom_range(nb - 1)), -1, 30, -1);
                2:       run_refill({$urandom, $urandom}, dly, -1, nb, -1, int'($urandom_range(nb - 1)), 30, -1);
                3:       run_refill({$urandom, $urandom}, dly, int'($urandom_range(dly)), nb, -1, -1, 30, -1);
                default: run_refill({$urandom, $urandom}, dly, -1, nb, -1, -1, 30, -1);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
